// File: rtl/link_frame_if.sv
// Signal bundle between the frame sequencer (master) and the link datapath (slave).
interface link_frame_if;
    logic        start;
    logic [15:0] src_data;
    logic [15:0] frame_src;
    logic        inter_en;
    logic        inter_eno;
    logic [27:0] inter_data;
    logic        sym_valid;
    logic [1:0]  sym_out;
    logic [1:0]  rx_sym;
    logic        deinter_en;
    logic [27:0] deinter_data;
    logic        deinter_eno;
    logic [15:0] dec_data;
    logic        busy;
    logic        done;
    logic [4:0]  bit_errs;
    logic [15:0] frame_cnt;
    logic [15:0] err_frame_cnt;
    logic        timeout;

    modport master (
        input  start, src_data, inter_eno, inter_data, rx_sym, deinter_eno, dec_data,
        output frame_src, inter_en, sym_valid, sym_out, deinter_en, deinter_data,
               busy, done, bit_errs, frame_cnt, err_frame_cnt, timeout
    );

    modport slave (
        output start, src_data, inter_eno, inter_data, rx_sym, deinter_eno, dec_data,
        input  frame_src, inter_en, sym_valid, sym_out, deinter_en, deinter_data,
               busy, done, bit_errs, frame_cnt, err_frame_cnt, timeout
    );
endinterface

// File: rtl/link_frame_sequencer.sv
// Frame controller: interleave, serialize to QPSK symbols, capture the channel
// output, deinterleave and score the decoded word against the source.
module link_frame_sequencer #(
    parameter int CHAN_LAT = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         rst,
    link_frame_if.master bus
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int LAT_W = $clog2(CHAN_LAT + 1) + 1;

    typedef enum logic [2:0] {IDLE, INTER, TX, DRAIN, DEINT, CHECK} state_t;

    state_t           state_q;
    logic [15:0]      frame_src_q;
    logic             inter_en_q;
    logic             sym_valid_q;
    logic [1:0]       sym_out_q;
    logic [25:0]      tx_sh_q;
    logic [3:0]       tx_idx_q;
    logic             deinter_en_q;
    logic [27:0]      deinter_data_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic [4:0]       bit_errs_q;
    logic [15:0]      frame_cnt_q;
    logic [15:0]      err_frame_cnt_q;
    logic [TMR_W-1:0] tmr_q;
    logic             rx_act_q;
    logic             rx_done_q;
    logic [LAT_W-1:0] rx_wait_q;
    logic [3:0]       rx_idx_q;

    logic [4:0]       bit_errs_d;
    logic [15:0]      frame_cnt_d;
    logic [15:0]      err_frame_cnt_d;
    logic             tmr_expired;

    assign tmr_expired = (tmr_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        bit_errs_d = '0;
        for (int i = 0; i < 16; i++) begin
            bit_errs_d = bit_errs_d + 5'(frame_src_q[i] ^ bus.dec_data[i]);
        end
        frame_cnt_d     = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
        err_frame_cnt_d = err_frame_cnt_q;
        if ((bit_errs_d != 5'd0) && (err_frame_cnt_q != 16'hFFFF)) begin
            err_frame_cnt_d = err_frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            frame_src_q     <= '0;
            inter_en_q      <= 1'b0;
            sym_valid_q     <= 1'b0;
            sym_out_q       <= '0;
            tx_sh_q         <= '0;
            tx_idx_q        <= '0;
            deinter_en_q    <= 1'b0;
            deinter_data_q  <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            timeout_q       <= 1'b0;
            bit_errs_q      <= '0;
            frame_cnt_q     <= '0;
            err_frame_cnt_q <= '0;
            tmr_q           <= '0;
            rx_act_q        <= 1'b0;
            rx_done_q       <= 1'b0;
            rx_wait_q       <= '0;
            rx_idx_q        <= '0;
        end else begin
            done_q <= 1'b0;

            // Receive capture trails the transmitter by CHAN_LAT+1 edges, independent of state.
            if (rx_act_q) begin
                if (rx_wait_q != LAT_W'(CHAN_LAT)) begin
                    rx_wait_q <= rx_wait_q + LAT_W'(1);
                end else begin
                    deinter_data_q[{rx_idx_q, 1'b0} +: 2] <= bus.rx_sym;
                    if (rx_idx_q == 4'd13) begin
                        rx_act_q  <= 1'b0;
                        rx_done_q <= 1'b1;
                    end else begin
                        rx_idx_q <= rx_idx_q + 4'd1;
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    // busy lingers for the single IDLE cycle that follows CHECK
                    busy_q <= bus.start;
                    if (bus.start) begin
                        frame_src_q <= bus.src_data;
                        timeout_q   <= 1'b0;
                        inter_en_q  <= 1'b1;
                        tmr_q       <= '0;
                        state_q     <= INTER;
                    end
                end
                INTER: begin
                    if (bus.inter_eno) begin
                        inter_en_q  <= 1'b0;
                        sym_valid_q <= 1'b1;
                        sym_out_q   <= bus.inter_data[1:0];
                        tx_sh_q     <= bus.inter_data[27:2];
                        tx_idx_q    <= '0;
                        rx_act_q    <= 1'b1;
                        rx_done_q   <= 1'b0;
                        rx_wait_q   <= '0;
                        rx_idx_q    <= '0;
                        state_q     <= TX;
                    end else if (tmr_expired) begin
                        inter_en_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                TX: begin
                    if (tx_idx_q == 4'd13) begin
                        sym_valid_q <= 1'b0;
                        state_q     <= DRAIN;
                    end else begin
                        sym_out_q <= tx_sh_q[1:0];
                        tx_sh_q   <= tx_sh_q >> 2;
                        tx_idx_q  <= tx_idx_q + 4'd1;
                    end
                end
                DRAIN: begin
                    if (rx_done_q) begin
                        deinter_en_q <= 1'b1;
                        tmr_q        <= '0;
                        state_q      <= DEINT;
                    end
                end
                DEINT: begin
                    if (bus.deinter_eno) begin
                        deinter_en_q <= 1'b0;
                        state_q      <= CHECK;
                    end else if (tmr_expired) begin
                        deinter_en_q <= 1'b0;
                        timeout_q    <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                CHECK: begin
                    bit_errs_q      <= bit_errs_d;
                    frame_cnt_q     <= frame_cnt_d;
                    err_frame_cnt_q <= err_frame_cnt_d;
                    done_q          <= 1'b1;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.frame_src     = frame_src_q;
    assign bus.inter_en      = inter_en_q;
    assign bus.sym_valid     = sym_valid_q;
    assign bus.sym_out       = sym_out_q;
    assign bus.deinter_en    = deinter_en_q;
    assign bus.deinter_data  = deinter_data_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.bit_errs      = bit_errs_q;
    assign bus.frame_cnt     = frame_cnt_q;
    assign bus.err_frame_cnt = err_frame_cnt_q;
    assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_link_frame_sequencer.sv
// Bench for link_frame_sequencer: clean 3-cycle channel model, eno responders
// with programmable latency, and a frame-level reference model.
module tb_link_frame_sequencer;
    localparam int CHAN_LAT = 3;
    localparam int TIMEOUT  = 64;
    localparam int NEVER    = 100000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    link_frame_if intf();

    link_frame_sequencer #(.CHAN_LAT(CHAN_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(intf)
    );

    int errors = 0;
    int checks = 0;

    // environment knobs
    logic [15:0] cur_src   = '0;
    logic [15:0] err_mask  = '0;
    logic [27:0] cur_idata = '0;
    int inter_lat   = 0;
    int deinter_lat = 0;
    int inter_cnt   = 0;
    int deinter_cnt = 0;
    logic [1:0] ch1 = '0, ch2 = '0, ch3 = '0;

    // observation
    logic [1:0] sym_q[$];
    int done_cnt = 0;

    // reference model state
    logic [15:0] mdl_frames = '0;
    logic [15:0] mdl_err_frames = '0;

    always @(posedge clk) begin
        ch1 <= intf.sym_out;
        ch2 <= ch1;
        ch3 <= ch2;
        inter_cnt   <= intf.inter_en   ? inter_cnt + 1   : 0;
        deinter_cnt <= intf.deinter_en ? deinter_cnt + 1 : 0;
    end

    assign intf.rx_sym      = ch3;
    assign intf.inter_eno   = intf.inter_en && (inter_cnt >= inter_lat);
    assign intf.inter_data  = cur_idata;
    assign intf.deinter_eno = intf.deinter_en && (deinter_cnt >= deinter_lat);
    assign intf.dec_data    = cur_src ^ err_mask;

    always @(negedge clk) begin
        if (intf.sym_valid) sym_q.push_back(intf.sym_out);
        if (intf.done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic run_frame(input string tag, input logic [15:0] src, input logic [27:0] idata,
                             input logic [15:0] mask, input int il, input int dl, input bit mid_start);
        int k;
        int dc0;
        bit seen;
        logic [27:0] sym_word;
        cur_src = src; cur_idata = idata; err_mask = mask;
        inter_lat = il; deinter_lat = dl;
        @(negedge clk);
        sym_q.delete();
        dc0 = done_cnt;
        intf.src_data = src;
        intf.start = 1'b1;
        k = 0; seen = 0;
        while (!seen && k < 400) begin
            @(negedge clk);
            k++;
            intf.start = 1'b0;
            if (k == 1) begin
                chk({tag, ".acc_busy"}, 32'(intf.busy), 32'd1);
                chk({tag, ".acc_inter_en"}, 32'(intf.inter_en), 32'd1);
                chk({tag, ".acc_timeout"}, 32'(intf.timeout), 32'd0);
                chk({tag, ".frame_src"}, 32'(intf.frame_src), 32'(src));
            end
            if (mid_start && k == 8) begin
                intf.start = 1'b1;
                intf.src_data = ~src;
            end
            if (intf.done) seen = 1;
        end
        // reference model: frame counters and scoring
        mdl_frames = sat_inc(mdl_frames);
        if (mask != 16'h0) mdl_err_frames = sat_inc(mdl_err_frames);
        sym_word = '0;
        foreach (sym_q[i]) sym_word = sym_word | (28'(sym_q[i]) << (2 * i));
        chk({tag, ".done_lat"}, 32'(k), 32'(14 + CHAN_LAT + 5 + il + dl));
        chk({tag, ".n_sym"}, 32'(sym_q.size()), 32'd14);
        chk({tag, ".sym_word"}, 32'(sym_word), 32'(idata));
        chk({tag, ".deinter_data"}, 32'(intf.deinter_data), 32'(idata));
        chk({tag, ".bit_errs"}, 32'(intf.bit_errs), 32'($countones(mask)));
        chk({tag, ".frame_cnt"}, 32'(intf.frame_cnt), 32'(mdl_frames));
        chk({tag, ".err_frame_cnt"}, 32'(intf.err_frame_cnt), 32'(mdl_err_frames));
        chk({tag, ".frame_src_hold"}, 32'(intf.frame_src), 32'(src));
        chk({tag, ".busy_at_done"}, 32'(intf.busy), 32'd1);
        @(negedge clk);
        chk({tag, ".busy_after"}, 32'(intf.busy), 32'd0);
        @(negedge clk);
        chk({tag, ".done_pulses"}, 32'(done_cnt - dc0), 32'd1);
    endtask

    task automatic run_timeout(input string tag, input int il, input int dl);
        int k;
        int dc0;
        int exp_k;
        cur_src = 16'h3C5A; cur_idata = 28'h1234567; err_mask = '0;
        inter_lat = il; deinter_lat = dl;
        exp_k = (dl == NEVER) ? (1 + il + 14 + CHAN_LAT + 1) + TIMEOUT + 1 : TIMEOUT + 1;
        @(negedge clk);
        dc0 = done_cnt;
        intf.src_data = cur_src;
        intf.start = 1'b1;
        k = 0;
        while (!intf.timeout && k < 400) begin
            @(negedge clk);
            k++;
            intf.start = 1'b0;
        end
        chk({tag, ".to_lat"}, 32'(k), 32'(exp_k));
        chk({tag, ".busy"}, 32'(intf.busy), 32'd0);
        chk({tag, ".enables"}, {30'd0, intf.inter_en, intf.deinter_en}, 32'd0);
        chk({tag, ".frame_cnt"}, 32'(intf.frame_cnt), 32'(mdl_frames));
        chk({tag, ".err_frame_cnt"}, 32'(intf.err_frame_cnt), 32'(mdl_err_frames));
        repeat (3) @(negedge clk);
        chk({tag, ".no_done"}, 32'(done_cnt - dc0), 32'd0);
        chk({tag, ".sticky"}, 32'(intf.timeout), 32'd1);
    endtask

    initial begin
        int k;
        logic [15:0] s;
        logic [27:0] d;
        logic [15:0] m;
        intf.start = 1'b0;
        intf.src_data = '0;

        repeat (3) @(negedge clk);
        chk("reset.ctrl", {22'd0, intf.inter_en, intf.sym_valid, intf.sym_out, intf.deinter_en,
                           intf.busy, intf.done, intf.timeout, 2'd0}, 32'd0);
        chk("reset.frame_cnt", 32'(intf.frame_cnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset.released_idle", {29'd0, intf.busy, intf.done, intf.timeout}, 32'd0);

        run_frame("clean", 16'h147C, 28'h8D3B2C6, 16'h0000, 0, 0, 0);
        run_frame("order", 16'h0F0F, 28'hA5C3F1E, 16'h0000, 0, 0, 0);
        chk("order.sym0", 32'(sym_q[0]), 32'd2);
        chk("order.sym1", 32'(sym_q[1]), 32'd3);
        chk("order.sym2", 32'(sym_q[2]), 32'd1);
        chk("order.sym3", 32'(sym_q[3]), 32'd0);
        chk("order.sym13", 32'(sym_q[13]), 32'd2);
        run_frame("err1", 16'h147C, 28'h5555AAA, 16'h0001, 1, 2, 0);
        run_frame("err16", 16'h147C, 28'h0F1E2D3, 16'hFFFF, 0, 0, 0);

        run_timeout("to_inter", NEVER, 0);
        run_frame("after_to", 16'hBEEF, 28'h3141592, 16'h0000, 0, 0, 0);
        run_timeout("to_deint", 0, NEVER);

        run_frame("mid_start", 16'h6A6A, 28'hC0FFEE1, 16'h0000, 0, 0, 1);

        // reset mid-TX aborts the frame and clears every output at once
        cur_src = 16'h1111; cur_idata = 28'h9ABCDEF; err_mask = '0; inter_lat = 0; deinter_lat = 0;
        @(negedge clk);
        intf.src_data = cur_src;
        intf.start = 1'b1;
        k = 0;
        while (!intf.sym_valid && k < 20) begin
            @(negedge clk);
            k++;
            intf.start = 1'b0;
        end
        chk("rst_mid.tx_reached", 32'(intf.sym_valid), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid.ctrl", {22'd0, intf.inter_en, intf.sym_valid, intf.sym_out, intf.deinter_en,
                             intf.busy, intf.done, intf.timeout, 2'd0}, 32'd0);
        chk("rst_mid.frame_src", 32'(intf.frame_src), 32'd0);
        chk("rst_mid.deinter_data", 32'(intf.deinter_data), 32'd0);
        chk("rst_mid.counts", {intf.frame_cnt, intf.err_frame_cnt}, 32'd0);
        chk("rst_mid.bit_errs", 32'(intf.bit_errs), 32'd0);
        mdl_frames = '0;
        mdl_err_frames = '0;
        @(negedge clk);
        rst = 1'b1;
        run_frame("post_rst", 16'h2468, 28'h7654321, 16'h0000, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            s = 16'($urandom);
            d = 28'($urandom);
            m = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000;
            run_frame($sformatf("rand%0d", i), s, d, m,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
        end

        // saturation: preload the frame counter at its ceiling
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        mdl_frames = 16'hFFFF;
        run_frame("sat", 16'hA0A0, 28'h0DEFACE, 16'h0300, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/link_frame_sequencer.md
# link_frame_sequencer

Frame-level controller for the Hamming/interleaver/QPSK/AWGN/deinterleaver link. On `start` it latches a 16-bit source word, enables the interleaver, serializes its 28-bit output into 14 QPSK symbols, and captures the demodulated symbols after a fixed channel latency. It then runs the deinterleaver and scores the decoded word against the source. It replaces ad-hoc counter sequencing in the link top level.

## Interface
Parameters:
- `CHAN_LAT`, 3: cycles from `sym_out` change to the matching `rx_sym` (modulator + channel + demodulator registers).
- `TIMEOUT`, 64: maximum cycles spent waiting on `inter_eno` or `deinter_eno`.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a frame; sampled only in IDLE.
- `src_data`  in  16  source word, latched on accepted `start`.
- `frame_src`  out  16  latched source word; drives the four Hamming encoders.
- `inter_en`  out  1  interleaver enable.
- `inter_eno`  in  1  interleaver output valid.
- `inter_data`  in  28  interleaved codeword.
- `sym_valid`  out  1  `sym_out` carries a frame symbol.
- `sym_out`  out  2  QPSK symbol to the modulator.
- `rx_sym`  in  2  demodulated symbol.
- `deinter_en`  out  1  deinterleaver enable.
- `deinter_data`  out  28  reassembled received codeword.
- `deinter_eno`  in  1  deinterleaver output valid.
- `dec_data`  in  16  Hamming-decoded word.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle pulse at frame completion.
- `bit_errs`  out  5  popcount(`frame_src` ^ `dec_data`) of the last frame, range 0..16.
- `frame_cnt`  out  16  completed frames; saturates at 16'hFFFF.
- `err_frame_cnt`  out  16  completed frames with `bit_errs`≠0; saturates.
- `timeout`  out  1  sticky; cleared by the next accepted `start`.

## Operation
- States: IDLE → INTER → TX → DRAIN → DEINT → CHECK → IDLE. Timeouts exit to IDLE.
- IDLE: `start`=1 latches `src_data` into `frame_src`, clears `timeout`, and moves to INTER. `start` in any other state is ignored.
- INTER: `inter_en`=1. When `inter_eno`=1, `inter_data` is latched into the TX shift register and the state moves to TX with `inter_en`=0. If `inter_eno` has not arrived after `TIMEOUT` cycles, the block sets `timeout`, drops `inter_en` and returns to IDLE. No `done`, and the counters do not change.
- TX: 14 cycles, `sym_valid`=1. Symbol k (k=0..13) is `inter_data[2k+1:2k]`, LSB pair first.
- Receive capture runs in parallel with TX: `rx_sym` sampled `CHAN_LAT` cycles after symbol k left is written to `deinter_data[2k+1:2k]`.
- DRAIN: waits until all 14 symbols are captured, then moves to DEINT.
- DEINT: `deinter_en`=1 until `deinter_eno`=1, then moves to CHECK. The timeout rule is the same as INTER.
- CHECK: one cycle. The block computes `bit_errs` from `dec_data`, increments `frame_cnt`, increments `err_frame_cnt` if `bit_errs`≠0, pulses `done`, and returns to IDLE.
- `deinter_data` and `bit_errs` hold their values until the next frame overwrites them.

## Timing
- Reset (`rst`=0, asynchronous) forces: state IDLE; `frame_src`, `deinter_data`, `sym_out`, `bit_errs`, `frame_cnt`, `err_frame_cnt` = 0; `inter_en`, `deinter_en`, `sym_valid`, `busy`, `done`, `timeout` = 0. Reset mid-frame aborts the frame with no `done`.
- `start` accepted at edge E0: INTER, `inter_en` and `busy` high from E0.
- `inter_eno` seen at edge Ei: `sym_out` carries symbol 0 from Ei, and symbol k from Ei+k.
- Symbol k is captured at edge Ei+k+`CHAN_LAT`+1. The last capture occurs at Ei+14+`CHAN_LAT`, after which `deinter_en` rises on the next edge.
- `deinter_eno` seen at edge Ed: CHECK at Ed+1; `done`, `bit_errs` and both counters are updated at the same edge, Ed+1; `busy` drops at Ed+2.
- With single-cycle `eno` responses, a frame takes 14+`CHAN_LAT`+5 cycles from `start` to `done`.
- A timeout is counted from entry into INTER or DEINT. `timeout` rises on edge `TIMEOUT` after entry, together with the return to IDLE.

## Test plan
- Clean loopback: model `rx_sym` as `sym_out` delayed 3 cycles and `dec_data`=`frame_src`; `src_data`=16'h147C → 14 `sym_valid` cycles, `deinter_data`=`inter_data`, `bit_errs`=0, `frame_cnt`=1, `err_frame_cnt`=0, one `done` pulse.
- Symbol ordering: `inter_data`=28'hA5C3F1E → first four `sym_out` values are 2,3,1,0 and the last is 2'b10.
- Error frame: `src_data`=16'h147C, `dec_data` forced to 16'h147D → `bit_errs`=1, `err_frame_cnt`=1; then 16'hEB83 (all 16 bits flipped) → `bit_errs`=16, `err_frame_cnt`=2.
- Timeout: `inter_eno` held 0 → `timeout`=1 exactly 64 cycles after INTER entry, `busy`=0, no `done`, `frame_cnt` unchanged; the next `start` clears `timeout`.
- Busy/reset: `start` pulsed during TX is ignored (only 14 symbols are sent); `rst`=0 asserted mid-TX → all outputs reach their reset values immediately, and a new frame then runs cleanly.
- Saturation: preload `frame_cnt` to 16'hFFFF via a forced state → after another frame it remains 16'hFFFF.
